// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared board constants and types for the input conditioner
//
// Purpose: board clock and debounce defaults, per-channel output bundle type,
//          and the debounce counter width helper.
// Contents:
//   CLK_FREQ_HZ             - board clock frequency
//   DEBOUNCE_MS_DEFAULT     - default debounce window in milliseconds
//   DEBOUNCE_CYCLES_DEFAULT - default debounce window in clock cycles
//   chan_out_t              - {toggle, fall, rise, clean} of one channel
//   cnt_width()             - counter width able to hold 0..cycles
package input_conditioner_pkg;

  localparam int CLK_FREQ_HZ             = 50_000_000;
  localparam int DEBOUNCE_MS_DEFAULT     = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

  typedef struct packed {
    logic toggle;
    logic fall;
    logic rise;
    logic clean;
  } chan_out_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-bit synchroniser, debouncer and edge/toggle logic
//
// Purpose: synchronise one asynchronous level, require DEBOUNCE_CYCLES
//          consecutive stable cycles before the clean level follows it, and
//          flag the resulting edges.
// Ports:
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset
//   raw_i  - asynchronous input level (polarity already corrected)
//   out_o  - {toggle, fall, rise, clean} for this channel
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      raw_i,
  output chan_out_t out_o
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          tog_q, tog_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // clean level; any return to agreement clears it, so a short excursion or a
  // bounce mid-count never reaches LAST and the count cannot wrap.
  always_comb begin
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    tog_d   = tog_q;
    cnt_d   = cnt_q;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      clean_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
      tog_d   = tog_q ^ s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o = '{toggle: tog_q, fall: fall_q, rise: rise_q, clean: clean_q};

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced switch/button front end for the gate-logic operands
//
// Purpose: per-channel polarity correction, synchronisation, debounce, edge
//          pulses and toggle state for N independent raw inputs.
// Ports:
//   CLK    - system clock
//   RST_N  - asynchronous active-low reset
//   RAW_IN - raw asynchronous switch/button pins
//   CLEAN  - debounced level per channel (bit 0 -> A, bit 1 -> B)
//   RISE   - one-cycle pulse when CLEAN rises
//   FALL   - one-cycle pulse when CLEAN falls
//   TOGGLE - flips on each RISE of its channel
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int           N               = 2,
  parameter int           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N-1:0] INVERT          = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] RAW_IN,
  output logic [N-1:0] CLEAN,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic [N-1:0] TOGGLE
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic      raw_pol;
    chan_out_t ch_out;

    // Active-low buttons are flipped before the synchroniser so every
    // downstream stage sees "pressed" as 1.
    assign raw_pol = RAW_IN[i] ^ INVERT[i];

    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .raw_i (raw_pol),
      .out_o (ch_out)
    );

    assign CLEAN[i]  = ch_out.clean;
    assign RISE[i]   = ch_out.rise;
    assign FALL[i]   = ch_out.fall;
    assign TOGGLE[i] = ch_out.toggle;
  end

endmodule
